// File: rtl/downstream_cancel_ledger_if.sv
// Event, lookup and update-report signals of the downstream cancel ledger.
// The exchange/risk side is the master; the ledger itself is the slave.
`timescale 1ns/1ps

interface downstream_cancel_ledger_if #(
    parameter int AMT_W = 16
) ();
    // Event handshake from the exchange side
    logic             evt_valid;
    logic             evt_ready;
    logic [4:0]       evt_client;
    logic [AMT_W-1:0] evt_amount;
    logic             evt_clear;

    // Lookup port feeding the upstream risk check
    logic [4:0]       query_id;
    logic [AMT_W-1:0] cancelled_orders;

    // Update report and status
    logic             upd_valid;
    logic [4:0]       upd_client;
    logic             saturated;

    modport master (
        output evt_valid, evt_client, evt_amount, evt_clear, query_id,
        input  evt_ready, cancelled_orders, upd_valid, upd_client, saturated
    );

    modport slave (
        input  evt_valid, evt_client, evt_amount, evt_clear, query_id,
        output evt_ready, cancelled_orders, upd_valid, upd_client, saturated
    );
endinterface

// File: rtl/downstream_cancel_ledger.sv
// Per-client running total of cancelled order amount. Events are applied by
// an IDLE -> READ -> WRITE read-modify-write sequencer; the total for
// query_id is served on a registered lookup port with write bypass.
`timescale 1ns/1ps

module downstream_cancel_ledger #(
    parameter int N_CLIENTS = 32,
    parameter int AMT_W     = 16
) (
    input  logic                     clk,
    input  logic                     HRESETn,
    downstream_cancel_ledger_if.slave bus
);

    localparam int               ID_W    = 5;
    localparam logic [ID_W:0]    N_LIM   = (ID_W+1)'(N_CLIENTS);
    localparam logic [AMT_W-1:0] AMT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  hold_client_q, hold_client_d;
    logic [AMT_W-1:0] hold_amount_q, hold_amount_d;
    logic             hold_clear_q, hold_clear_d;
    logic [AMT_W-1:0] old_q, old_d;
    logic [AMT_W-1:0] table_q [N_CLIENTS];
    logic [AMT_W-1:0] table_d [N_CLIENTS];
    logic [AMT_W-1:0] cancelled_q, cancelled_d;
    logic             upd_valid_q, upd_valid_d;
    logic [ID_W-1:0]  upd_client_q, upd_client_d;
    logic             saturated_q, saturated_d;

    logic             evt_ready;
    logic             hold_in_range;
    logic             query_in_range;
    logic             write_en;
    logic [AMT_W:0]   sum;
    logic             sat_hit;
    logic [AMT_W-1:0] new_val;

    // Ready only in IDLE and never while reset is asserted.
    assign evt_ready = (state_q == IDLE) && HRESETn;

    assign hold_in_range  = ({1'b0, hold_client_q} < N_LIM);
    assign query_in_range = ({1'b0, bus.query_id}  < N_LIM);

    // Saturating add of the held amount onto the entry read in READ.
    always_comb begin
        sum     = {1'b0, old_q} + {1'b0, hold_amount_q};
        sat_hit = !hold_clear_q && sum[AMT_W];
        if (hold_clear_q) begin
            new_val = '0;
        end else if (sat_hit) begin
            new_val = AMT_MAX;
        end else begin
            new_val = sum[AMT_W-1:0];
        end
    end

    // Sequencer next state, table update, update report and lookup.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        hold_client_d = hold_client_q;
        hold_amount_d = hold_amount_q;
        hold_clear_d  = hold_clear_q;
        old_d         = old_q;
        table_d       = table_q;
        upd_valid_d   = 1'b0;
        upd_client_d  = upd_client_q;
        saturated_d   = saturated_q;
        write_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.evt_valid && evt_ready) begin
                    hold_client_d = bus.evt_client;
                    hold_amount_d = bus.evt_amount;
                    hold_clear_d  = bus.evt_clear;
                    state_d       = READ;
                end
            end
            READ: begin
                old_d   = hold_in_range ? table_q[hold_client_q] : '0;
                state_d = WRITE;
            end
            WRITE: begin
                // Out-of-range ids are dropped but still report an update.
                write_en = hold_in_range;
                if (write_en) begin
                    table_d[hold_client_q] = new_val;
                end
                if (sat_hit) begin
                    saturated_d = 1'b1;
                end
                upd_valid_d  = 1'b1;
                upd_client_d = hold_client_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lookup forwards a same-edge write so the risk check never sees a stale total.
        cancelled_d = query_in_range ? table_q[bus.query_id] : '0;
        if (write_en && (hold_client_q == bus.query_id)) begin
            cancelled_d = new_val;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!HRESETn) begin
            state_q       <= IDLE;
            hold_client_q <= '0;
            hold_amount_q <= '0;
            hold_clear_q  <= 1'b0;
            old_q         <= '0;
            cancelled_q   <= '0;
            upd_valid_q   <= 1'b0;
            upd_client_q  <= '0;
            saturated_q   <= 1'b0;
            // NOTE: the table is built from flops, not RAM, because reset must clear every entry in one cycle.
            for (int i = 0; i < N_CLIENTS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            hold_client_q <= hold_client_d;
            hold_amount_q <= hold_amount_d;
            hold_clear_q  <= hold_clear_d;
            old_q         <= old_d;
            cancelled_q   <= cancelled_d;
            upd_valid_q   <= upd_valid_d;
            upd_client_q  <= upd_client_d;
            saturated_q   <= saturated_d;
            table_q       <= table_d;
        end
    end

    assign bus.evt_ready        = evt_ready;
    assign bus.cancelled_orders = cancelled_q;
    assign bus.upd_valid        = upd_valid_q;
    assign bus.upd_client       = upd_client_q;
    assign bus.saturated        = saturated_q;

endmodule

// File: tb/tb_downstream_cancel_ledger.sv
// Directed bench for downstream_cancel_ledger: reset, accumulation,
// saturation/clear, write bypass, mid-operation reset and back-to-back events.
`timescale 1ns/1ps

module tb_downstream_cancel_ledger;

    logic clk = 1'b0;
    logic HRESETn;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   upd_cnt  = 0;
    int   acc_cnt  = 0;

    always #5 clk = ~clk;

    downstream_cancel_ledger_if #(.AMT_W(16)) bus ();

    downstream_cancel_ledger #(.N_CLIENTS(32), .AMT_W(16)) dut (
        .clk     (clk),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    // Count update pulses and accepts away from the active edge.
    always @(negedge clk) begin
        if (bus.upd_valid === 1'b1) upd_cnt++;
        if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) acc_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ready, present one event, and return just after the write edge.
    task automatic do_event(input logic [4:0] c, input logic [15:0] a, input logic clr, output int waited);
        waited = 0;
        while (bus.evt_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (bus.evt_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL evt_timeout: evt_ready=%0b after %0d cycles, want 1", bus.evt_ready, waited);
        end
        bus.evt_valid  = 1'b1;
        bus.evt_client = c;
        bus.evt_amount = a;
        bus.evt_clear  = clr;
        tick();
        bus.evt_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        HRESETn        = 1'b0;
        bus.evt_valid  = 1'b0;
        bus.evt_client = '0;
        bus.evt_amount = '0;
        bus.evt_clear  = 1'b0;
        bus.query_id   = '0;
        tick();
        n_checks++; if (bus.evt_ready !== 1'b0) $display("FAIL reset_ready_c1: evt_ready=%0b want 0", bus.evt_ready); else n_pass++;
        tick();
        n_checks++; if (bus.evt_ready !== 1'b0) $display("FAIL reset_ready_c2: evt_ready=%0b want 0", bus.evt_ready); else n_pass++;
        n_checks++; if (bus.upd_valid !== 1'b0) $display("FAIL reset_upd_valid: upd_valid=%0b want 0", bus.upd_valid); else n_pass++;
        n_checks++; if (bus.saturated !== 1'b0) $display("FAIL reset_saturated: saturated=%0b want 0", bus.saturated); else n_pass++;
        HRESETn = 1'b1;
        bus.query_id = 5'd0;
        tick();
        n_checks++; if (bus.evt_ready !== 1'b1) $display("FAIL reset_release_ready: evt_ready=%0b want 1", bus.evt_ready); else n_pass++;
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL reset_query0: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
        bus.query_id = 5'd5;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL reset_query5: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
        bus.query_id = 5'd31;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL reset_query31: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
    endtask

    task automatic test_accumulate();
        int w;
        int u0;
        u0 = upd_cnt;
        bus.query_id = 5'd7;
        do_event(5'd7, 16'd100, 1'b0, w);
        n_checks++; if (bus.upd_valid !== 1'b1) $display("FAIL acc_upd1: upd_valid=%0b want 1", bus.upd_valid); else n_pass++;
        n_checks++; if (bus.upd_client !== 5'd7) $display("FAIL acc_client1: upd_client=%0d want 7", bus.upd_client); else n_pass++;
        n_checks++; if (bus.evt_ready !== 1'b1) $display("FAIL acc_ready_back: evt_ready=%0b want 1", bus.evt_ready); else n_pass++;
        do_event(5'd7, 16'd250, 1'b0, w);
        n_checks++; if (w !== 0) $display("FAIL acc_gap: extra wait=%0d cycles want 0 (accepts 3 apart)", w); else n_pass++;
        n_checks++; if (bus.upd_client !== 5'd7) $display("FAIL acc_client2: upd_client=%0d want 7", bus.upd_client); else n_pass++;
        n_checks++; if (bus.cancelled_orders !== 16'd350) $display("FAIL acc_bypass350: cancelled_orders=%0d want 350", bus.cancelled_orders); else n_pass++;
        tick();
        n_checks++; if (bus.upd_valid !== 1'b0) $display("FAIL acc_pulse_width: upd_valid=%0b want 0", bus.upd_valid); else n_pass++;
        n_checks++; if (upd_cnt - u0 !== 2) $display("FAIL acc_pulses: pulses=%0d want 2", upd_cnt - u0); else n_pass++;
        n_checks++; if (bus.cancelled_orders !== 16'd350) $display("FAIL acc_query7: cancelled_orders=%0d want 350", bus.cancelled_orders); else n_pass++;
    endtask

    task automatic test_saturation_clear();
        int w;
        bus.query_id = 5'd3;
        do_event(5'd3, 16'hFFF0, 1'b0, w);
        n_checks++; if (bus.saturated !== 1'b0) $display("FAIL sat_early: saturated=%0b want 0", bus.saturated); else n_pass++;
        n_checks++; if (bus.upd_client !== 5'd3) $display("FAIL sat_client: upd_client=%0d want 3", bus.upd_client); else n_pass++;
        do_event(5'd3, 16'h0020, 1'b0, w);
        n_checks++; if (bus.saturated !== 1'b1) $display("FAIL sat_set: saturated=%0b want 1", bus.saturated); else n_pass++;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'hFFFF) $display("FAIL sat_value: cancelled_orders=%h want ffff", bus.cancelled_orders); else n_pass++;
        do_event(5'd3, 16'h1234, 1'b1, w);
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL clear_value: cancelled_orders=%h want 0000", bus.cancelled_orders); else n_pass++;
        n_checks++; if (bus.saturated !== 1'b1) $display("FAIL clear_keeps_sat: saturated=%0b want 1", bus.saturated); else n_pass++;
        // Adding zero still writes and pulses.
        bus.query_id = 5'd7;
        do_event(5'd7, 16'd0, 1'b0, w);
        n_checks++; if (bus.upd_valid !== 1'b1) $display("FAIL add0_pulse: upd_valid=%0b want 1", bus.upd_valid); else n_pass++;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd350) $display("FAIL add0_value: cancelled_orders=%0d want 350", bus.cancelled_orders); else n_pass++;
    endtask

    task automatic test_bypass();
        bus.query_id = 5'd9;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL byp_before: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
        n_checks++; if (bus.evt_ready !== 1'b1) $display("FAIL byp_ready: evt_ready=%0b want 1", bus.evt_ready); else n_pass++;
        bus.evt_valid  = 1'b1;
        bus.evt_client = 5'd9;
        bus.evt_amount = 16'd40;
        bus.evt_clear  = 1'b0;
        tick();
        bus.evt_valid = 1'b0;
        n_checks++; if (bus.evt_ready !== 1'b0) $display("FAIL byp_busy_read: evt_ready=%0b want 0", bus.evt_ready); else n_pass++;
        tick();
        n_checks++; if (bus.evt_ready !== 1'b0) $display("FAIL byp_busy_write: evt_ready=%0b want 0", bus.evt_ready); else n_pass++;
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL byp_pre_write: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd40) $display("FAIL byp_write_edge: cancelled_orders=%0d want 40", bus.cancelled_orders); else n_pass++;
        n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_client !== 5'd9) $display("FAIL byp_upd: upd_valid=%0b upd_client=%0d want 1/9", bus.upd_valid, bus.upd_client); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int u0;
        bus.query_id = 5'd12;
        tick();
        bus.evt_valid  = 1'b1;
        bus.evt_client = 5'd12;
        bus.evt_amount = 16'd500;
        bus.evt_clear  = 1'b0;
        tick();
        bus.evt_valid = 1'b0;
        u0 = upd_cnt;
        HRESETn = 1'b0;
        #1;
        n_checks++; if (bus.evt_ready !== 1'b0) $display("FAIL mid_ready: evt_ready=%0b want 0", bus.evt_ready); else n_pass++;
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (upd_cnt !== u0) $display("FAIL mid_no_pulse: pulses=%0d want 0", upd_cnt - u0); else n_pass++;
        n_checks++; if (bus.cancelled_orders !== 16'd0) $display("FAIL mid_entry12: cancelled_orders=%0d want 0", bus.cancelled_orders); else n_pass++;
        n_checks++; if (bus.saturated !== 1'b0) $display("FAIL mid_sat_cleared: saturated=%0b want 0", bus.saturated); else n_pass++;
        n_checks++; if (bus.evt_ready !== 1'b1) $display("FAIL mid_ready_back: evt_ready=%0b want 1", bus.evt_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ids  [4];
        logic [15:0] amts [4];
        int   k;
        int   a0;
        int   u0;
        logic acc;
        ids  = '{5'd1, 5'd2, 5'd1, 5'd2};
        amts = '{16'd10, 16'd20, 16'd30, 16'd40};
        k  = 0;
        a0 = acc_cnt;
        u0 = upd_cnt;
        bus.evt_valid  = 1'b1;
        bus.evt_client = ids[0];
        bus.evt_amount = amts[0];
        bus.evt_clear  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            acc = bus.evt_ready;
            tick();
            if (acc === 1'b1) begin
                k++;
                if (k < 4) begin
                    bus.evt_client = ids[k];
                    bus.evt_amount = amts[k];
                end
            end
        end
        bus.evt_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (acc_cnt - a0 !== 4) $display("FAIL b2b_accepts: accepts=%0d want 4", acc_cnt - a0); else n_pass++;
        n_checks++; if (upd_cnt - u0 !== 4) $display("FAIL b2b_pulses: pulses=%0d want 4", upd_cnt - u0); else n_pass++;
        bus.query_id = 5'd1;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd40) $display("FAIL b2b_client1: cancelled_orders=%0d want 40", bus.cancelled_orders); else n_pass++;
        bus.query_id = 5'd2;
        tick();
        n_checks++; if (bus.cancelled_orders !== 16'd60) $display("FAIL b2b_client2: cancelled_orders=%0d want 60", bus.cancelled_orders); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_saturation_clear();
        test_bypass();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/downstream_cancel_ledger.md
# downstream_cancel_ledger

Downstream counterpart of the upstream order processor. It accepts cancel and clear events from the exchange side and keeps a per-client running total of cancelled order amount in a 32-entry table. It serves that total on a registered lookup port, which drives the `cancelled_orders` input that the upstream risk check subtracts from its accumulated orders. Updates use a three-state read-modify-write sequencer behind a valid/ready handshake.

## Interface
- `N_CLIENTS`, 32: table depth; one entry per client id.
- `AMT_W`, 16: width of amounts and of table entries.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `HRESETn`  in  1  reset, synchronous, active-low.
- `evt_valid`  in  1  an event is presented.
- `evt_ready`  out  1  the block can accept an event this cycle.
- `evt_client`  in  5  client id of the event.
- `evt_amount`  in  AMT_W  cancelled amount, unsigned; ignored when `evt_clear`=1.
- `evt_clear`  in  1  1 = set the entry to 0; 0 = add `evt_amount` to the entry.
- `query_id`  in  5  client id to look up (the upstream `client_id`).
- `cancelled_orders`  out  AMT_W  registered table value for `query_id`.
- `upd_valid`  out  1  one-cycle pulse after each table write.
- `upd_client`  out  5  client id written; valid while `upd_valid`=1.
- `saturated`  out  1  sticky flag: some add clamped at the maximum value.

## Operation
- The FSM has three states: IDLE, READ and WRITE.
- `evt_ready` = (state==IDLE) && HRESETn.
- Accept handshake: `evt_valid` && `evt_ready` at a rising edge.
  - `evt_client`, `evt_amount` and `evt_clear` are latched into holding registers.
  - The FSM moves IDLE->READ.
  - Inputs are not sampled again until the next accept.
- READ: the entry table[held client] is latched into `old_q`. The FSM moves READ->WRITE.
- WRITE: the table entry is written with `new_val`. The FSM moves WRITE->IDLE.
  - `upd_valid` is registered to 1 and `upd_client` to the held client, so both are visible in the following cycle.
- `new_val` arithmetic:
  - If clear: `new_val` = 0.
  - Otherwise compute the 17-bit sum `old_q` + amount.
  - If bit 16 of the sum is set, `new_val` = 16'hFFFF and `saturated` is set to 1.
  - Otherwise `new_val` = sum[15:0].
- A clear never touches `saturated`.
- An add of 0 performs a write of the unchanged value and still pulses `upd_valid`.
- Lookup: on every edge, `cancelled_orders` <= table[`query_id`].
  - If the same edge writes entry `query_id`, `cancelled_orders` takes `new_val` (write bypass), never the stale value.
- Client ids outside 0..N_CLIENTS-1 cannot occur at N_CLIENTS=32.
- With a smaller N_CLIENTS, such events are accepted and dropped: no write, and `upd_valid` still pulses. Lookups of such ids return 0.

## Timing
- Reset is synchronous. On an edge where HRESETn=0:
  - State goes to IDLE.
  - All table entries are set to 0.
  - `cancelled_orders`=0, `upd_valid`=0, `upd_client`=0, `saturated`=0.
  - `evt_ready` is 0 for the whole cycle in which HRESETn=0.
- Reset mid-operation (state READ or WRITE) aborts the event. The table is not written and no `upd_valid` pulse is produced.
- Event latency, with accept at edge N:
  - The table is written at edge N+2.
  - `upd_valid` is high during cycle N+2..N+3.
  - `evt_ready` returns high after edge N+2.
  - The earliest next accept is edge N+3.
- Throughput: one event every 3 cycles at most.
- `evt_valid` may be held high continuously. Each accept consumes exactly one event.
- Lookup latency is 1 cycle. A `query_id` applied before edge N is reflected in `cancelled_orders` after edge N.
- Lookups are independent of the FSM state and never stall.

## Test plan
- Reset then lookup:
  - Stimulus: hold HRESETn=0 for 2 cycles, release, then query ids 0, 5 and 31.
  - Required: `cancelled_orders`=0 for every id, `evt_ready`=0 during reset, `saturated`=0.
- Accumulate:
  - Stimulus: add 100 then 250 to client 7.
  - Required: `upd_valid` pulses twice with `upd_client`=7; query 7 returns 350; ready gaps are exactly 3 cycles apart.
- Saturation and clear:
  - Stimulus: add 16'hFFF0 then 16'h0020 to client 3.
  - Required: entry becomes 16'hFFFF and `saturated`=1.
  - Stimulus: clear client 3.
  - Required: entry becomes 0 and `saturated` stays 1.
- Write bypass:
  - Stimulus: hold `query_id`=9 and add 40 to client 9.
  - Required: `cancelled_orders` changes 0->40 on the same edge that writes the table.
- Mid-operation reset:
  - Stimulus: add 500 to client 12 and drop HRESETn in the cycle after accept (READ).
  - Required: no `upd_valid` pulse; entry 12 reads 0 after reset.
- Back-to-back:
  - Stimulus: hold `evt_valid`=1 with events alternating between client 1 and client 2 for 12 cycles.
  - Required: 4 accepts, 4 `upd_valid` pulses, and correct per-client totals.
